// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: control in, IM read port, and the valid/ready port into decode.
// master = fetch_queue side, slave = memory/decode/control side.
interface fetch_queue_if #(
  parameter int AW = 16,
  parameter int OW = 3
);
  logic          fetch_en;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] im_addr;
  logic          im_rd_en;
  logic [15:0]   im_data;
  logic          id_valid;
  logic          id_ready;
  logic [15:0]   id_instr;
  logic [AW-1:0] id_pc;
  logic [OW-1:0] occupancy;

  modport master (
    input  fetch_en, redirect, redirect_pc, im_data, id_ready,
    output im_addr, im_rd_en, id_valid, id_instr, id_pc, occupancy
  );

  modport slave (
    output fetch_en, redirect, redirect_pc, im_data, id_ready,
    input  im_addr, im_rd_en, id_valid, id_instr, id_pc, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, reads the synchronous IM and
// queues {instr, pc} pairs for decode; a redirect flushes and restarts fetch.
module fetch_queue #(
  parameter int            DEPTH    = 4,
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] inflight_pc;
  logic          inflight;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] count;

  logic [15:0]   instr_mem [DEPTH];
  logic [AW-1:0] pc_mem    [DEPTH];

  logic          valid;
  logic          pop;
  logic          push;
  logic          issue;
  logic [OW:0]   reserved;

  // A slot is reserved at issue time, so the in-flight read counts against capacity.
  always_comb begin
    valid    = (count != '0) & ~bus.redirect;
    pop      = valid & bus.id_ready;
    push     = inflight & ~bus.redirect;
    reserved = {1'b0, count} + (OW+1)'(inflight) - (OW+1)'(pop);
    issue    = bus.fetch_en & ~bus.redirect & ~rst & (reserved < (OW+1)'(DEPTH));
  end

  assign bus.im_addr   = fetch_pc;
  assign bus.im_rd_en  = issue;
  assign bus.id_valid  = valid;
  assign bus.occupancy = count;
  // Head is gated by occupancy so that an emptied queue (reset included) shows zeros.
  assign bus.id_instr  = (count != '0) ? instr_mem[rd_ptr] : 16'h0;
  assign bus.id_pc     = (count != '0) ? pc_mem[rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.im_data;
      pc_mem[wr_ptr]    <= inflight_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (bus.redirect) begin
      // The word in flight belongs to the old path and is dropped.
      fetch_pc <= bus.redirect_pc;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + OW'(push) - OW'(pop);
    end
  end
endmodule
